// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq
//  Description : Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU.
//                It retires BITS_PER_CYCLE multiplier bits per cycle and
//                returns the selected half of the 2*XLEN product.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_seq #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int ITERS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e              state_q,  state_d;
  logic [2*XLEN-1:0]   mcand_q,  mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q,    acc_d;
  logic [CW-1:0]       cnt_q,    cnt_d;
  logic                neg_q,    neg_d;
  logic [1:0]          op_q,     op_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_neg, b_neg;
  logic [2*XLEN-1:0]   partial;
  logic [2*XLEN-1:0]   product;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;

    a_neg   = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && a_i[XLEN-1];
    b_neg   = (op_i == OP_MULH) && b_i[XLEN-1];
    // Operands are held as magnitudes; the sign is re-applied once in FIXUP.
    partial = mcand_q * {{(2*XLEN-BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};
    product = neg_q ? -acc_q : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d  = S_CALC;
          mcand_d  = {{XLEN{1'b0}}, (a_neg ? -a_i : a_i)};
          mplier_d = b_neg ? -b_i : b_i;
          neg_d    = a_neg ^ b_neg;
          op_d     = op_i;
          acc_d    = '0;
          cnt_d    = CW'(ITERS);
        end
      end
      S_CALC: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        result_d = (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An aborted op must leave the previous result visible.
    if (flush_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule
`default_nettype wire
